seq_divider: RTL and testbench

- Multi-cycle unsigned restoring (shift-subtract) divider; the inverse datapath to the team's shift-add multiplier.
- Integer unit: controller FSM, operand/remainder registers, iteration counter, start/done handshake.
- Produces one quotient bit per clock.
- Instantiated beside the multiplier in the arithmetic block.

---
 rtl/seq_divider_pkg.sv | 11 +
 rtl/seq_divider_div_step.sv | 18 +
 rtl/seq_divider.sv | 126 ++++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} div_state_t;

  // Iteration counter width; it only ever holds WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: trial subtract of D from the shifted remainder.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  assign trial  = r_shift - {1'b0, d};
  assign q_bit  = ~trial[WIDTH];
  // When the trial fails r_shift < d, so its top bit is already zero.
  assign r_next = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (C truncation).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t state, state_nxt;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // R's top bit is always zero between steps, so only the low WIDTH bits are kept.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    counter;

  logic             accept;
  logic             dz;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  assign dz      = (divisor == '0);
  assign accept  = start && (state == IDLE || state == DONE);
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign q_next  = {q_reg[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .r_shift (r_shift),
    .d       (d_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = dz ? DONE : DIVIDE;
      DIVIDE:     if (counter == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    busy = (state == DIVIDE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      counter     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      q_reg   <= a_mag;
      d_reg   <= b_mag;
      r_reg   <= '0;
      counter <= CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r   <= dividend[WIDTH-1];
`endif
      // Divide-by-zero enters DONE on this same edge, so results land now.
      if (dz) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == DIVIDE) begin
      q_reg <= q_next;
      r_reg <= r_next;
      if (counter != '0) begin
        counter <= counter - CW'(1);
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        quotient  <= neg_q ? -q_next : q_next;
        remainder <= neg_r ? -r_next : r_next;
`else
        quotient  <= q_next;
        remainder <= r_next;
`endif
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: cycle-level timing model plus arithmetic reference.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Timing model: cycles left in the divide, whether DONE is held, and a fresh-result flag.
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_new = 1'b0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_new  = 1'b0;
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_new  = 1'b1;
      end
    end else if (start) begin
      exp_q.push_back(ref_div(dividend, divisor));
      if (divisor == '0) begin
        m_done = 1'b1;
        m_new  = 1'b1;
      end else begin
        m_left = W;
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_new && done) begin
        if (exp_q.size() == 0) begin
          chk("result_queue_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          last_q = e.q;
          last_r = e.r;
          last_z = e.z;
        end
      end
      m_new = 1'b0;
      chk("quotient", 32'(quotient), 32'(last_q));
      chk("remainder", 32'(remainder), 32'(last_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(last_z));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_cleared();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    #1;
    chk_cleared();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(8'h9C, 8'd7);   wait_done();
    chk("s_neg_dividend_q", 32'(quotient), 32'hF2);
    chk("s_neg_dividend_r", 32'(remainder), 32'hFE);
    issue(8'd100, 8'hF9); wait_done();
    chk("s_neg_divisor_q", 32'(quotient), 32'hF2);
    chk("s_neg_divisor_r", 32'(remainder), 32'h02);
    issue(8'h80, 8'hFF);  wait_done();
    chk("s_wrap_q", 32'(quotient), 32'h80);
    chk("s_wrap_r", 32'(remainder), 32'h00);
`else
    issue(8'd100, 8'd7);  wait_done();
    chk("q_100_7", 32'(quotient), 32'd14);
    chk("r_100_7", 32'(remainder), 32'd2);
    issue(8'h5A, 8'd0);   wait_done();
    chk("q_div0", 32'(quotient), 32'hFF);
    chk("r_div0", 32'(remainder), 32'h5A);
    chk("z_div0", 32'(div_by_zero), 32'd1);
    issue(8'd5, 8'd9);    wait_done();
    chk("q_small", 32'(quotient), 32'd0);
    chk("r_small", 32'(remainder), 32'd5);
    issue(8'hFF, 8'd1);   wait_done();
    chk("q_div1", 32'(quotient), 32'hFF);
    chk("r_div1", 32'(remainder), 32'd0);
    issue(8'd0, 8'd37);   wait_done();
    chk("q_zero", 32'(quotient), 32'd0);
    chk("r_zero", 32'(remainder), 32'd0);
`endif

    // Start held high: DONE must relaunch each time, giving single-cycle done pulses.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd10;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a divide.
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_cleared();
    @(negedge clk);
    reset = 1'b0;
    issue(8'd50, 8'd3);   wait_done();
    chk("q_after_reset", 32'(quotient), 32'd16);
    chk("r_after_reset", 32'(remainder), 32'd2);

    // Random traffic: pulses, held starts and operand churn while busy.
    repeat (600) begin
      @(negedge clk);
      start    = ($urandom_range(2) == 0);
      dividend = W'($urandom);
      case ($urandom_range(7))
        0:       divisor = '0;
        1:       divisor = W'(1);
        2:       divisor = W'($urandom_range(3));
        default: divisor = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
